// File: rtl/gaussian_conv_mac.sv
// gaussian_conv_mac: consumes one kxk window per output pixel, multiplies it
// sequentially against a kxk coefficient table, then rounds, shifts and
// saturates the sum into one pixel handed downstream with valid/ready.
module gaussian_conv_mac #(
  parameter int MAX_KERNEL  = 31,
  parameter int PIXEL_DEPTH = 8,
  parameter int COEFF_DEPTH = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [$clog2(MAX_KERNEL)-1:0]                kernel_size,
  input  logic [4:0]                                   norm_shift,
  input  logic                                         new_sample_ready,
  input  logic [MAX_KERNEL*MAX_KERNEL*PIXEL_DEPTH-1:0] working_memory,
  input  logic                                         end_pos,
  output logic                                         new_trans,
  output logic                                         new_sample_req,
  output logic                                         update_pos,
  output logic [$clog2(MAX_KERNEL)-1:0]                coeff_x,
  output logic [$clog2(MAX_KERNEL)-1:0]                coeff_y,
  output logic                                         coeff_ren,
  input  logic [COEFF_DEPTH-1:0]                       coeff_rdata,
  output logic [PIXEL_DEPTH-1:0]                       pix_out,
  output logic                                         pix_valid,
  input  logic                                         pix_ready,
  output logic                                         done
);

  localparam int KW    = $clog2(MAX_KERNEL);
  localparam int ACC_W = PIXEL_DEPTH + COEFF_DEPTH + 2 * KW;
  localparam int NPIX  = MAX_KERNEL * MAX_KERNEL;
  localparam int IDX_W = $clog2(NPIX);
  // Rounding constant can reach 2^30, so the rounded sum needs headroom above ACC_W.
  localparam int SUM_W = ACC_W + 32;
  localparam logic [PIXEL_DEPTH-1:0] PIX_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_MAC, S_DRAIN, S_NORM, S_OUT, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [KW-1:0]          k_reg;
  logic [4:0]             shift_reg;
  logic [KW-1:0]          x_reg, y_reg;
  logic [ACC_W-1:0]       acc_reg;
  logic [PIXEL_DEPTH-1:0] pix_reg;
  logic                   mac_valid_reg;
  logic [PIXEL_DEPTH-1:0] pix_out_reg;
  logic                   done_reg;

  logic                   last_addr;
  logic [IDX_W-1:0]       win_idx;
  logic [SUM_W-1:0]       round_sum, shifted;
  logic [PIXEL_DEPTH-1:0] sat_pix;
  logic [ACC_W-1:0]       product;

  // Unpack the flat window bus; pixel (x,y) sits at index x*MAX_KERNEL + y.
  logic [PIXEL_DEPTH-1:0] win [NPIX];
  for (genvar gi = 0; gi < NPIX; gi++) begin : g_unpack
    assign win[gi] = working_memory[gi*PIXEL_DEPTH +: PIXEL_DEPTH];
  end

  assign win_idx   = IDX_W'(x_reg) * IDX_W'(MAX_KERNEL) + IDX_W'(y_reg);
  assign last_addr = (x_reg == k_reg - 1'b1) && (y_reg == k_reg - 1'b1);
  assign product   = ACC_W'(pix_reg) * ACC_W'(coeff_rdata);
  assign coeff_x   = x_reg;
  assign coeff_y   = y_reg;
  assign pix_out   = pix_out_reg;
  assign done      = done_reg;

  // Round half up, shift down, clamp to the pixel range.
  always_comb begin
    round_sum = SUM_W'(acc_reg);
    if (shift_reg != 5'd0)
      round_sum = round_sum + (SUM_W'(1) << (shift_reg - 5'd1));
    shifted = round_sum >> shift_reg;
    sat_pix = (shifted > SUM_W'(PIX_MAX)) ? PIX_MAX : shifted[PIXEL_DEPTH-1:0];
  end

  // Next-state and handshake pulses; pulses are suppressed while reset is held.
  always_comb begin
    state_next     = state_reg;
    new_trans      = 1'b0;
    new_sample_req = 1'b0;
    update_pos     = 1'b0;
    coeff_ren      = 1'b0;
    pix_valid      = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start && kernel_size != '0 && !rst) begin
          new_trans  = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (new_sample_ready) begin
          new_sample_req = 1'b1;
          state_next     = S_MAC;
        end
      end
      S_MAC: begin
        coeff_ren = 1'b1;
        if (last_addr) state_next = S_DRAIN;
      end
      S_DRAIN: state_next = S_NORM;
      S_NORM:  state_next = S_OUT;
      S_OUT: begin
        pix_valid = 1'b1;
        if (pix_ready) begin
          update_pos = !end_pos;
          state_next = end_pos ? S_DONE : S_WAIT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Frame configuration and the done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg     <= '0;
      shift_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      if (new_trans) begin
        k_reg     <= kernel_size;
        shift_reg <= norm_shift;
        done_reg  <= 1'b0;
      end
      if (state_reg == S_OUT && pix_ready && end_pos)
        done_reg <= 1'b1;
    end
  end

  // MAC datapath: address walk, pixel pipeline register, accumulate, output latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg         <= '0;
      y_reg         <= '0;
      acc_reg       <= '0;
      pix_reg       <= '0;
      mac_valid_reg <= 1'b0;
      pix_out_reg   <= '0;
    end else begin
      mac_valid_reg <= coeff_ren;
      if (new_sample_req) begin
        acc_reg <= '0;
        x_reg   <= '0;
        y_reg   <= '0;
      end else begin
        if (mac_valid_reg)
          acc_reg <= acc_reg + product;
        if (coeff_ren) begin
          if (last_addr) begin
            x_reg <= '0;
            y_reg <= '0;
          end else if (x_reg == k_reg - 1'b1) begin
            x_reg <= '0;
            y_reg <= y_reg + 1'b1;
          end else begin
            x_reg <= x_reg + 1'b1;
          end
        end
      end
      if (coeff_ren)
        pix_reg <= win[win_idx];
      if (state_reg == S_NORM)
        pix_out_reg <= sat_pix;
    end
  end

endmodule

// File: tb/tb_gaussian_conv_mac.sv
// Testbench for gaussian_conv_mac: directed frames with hand-computed pixels,
// plus a per-cycle behavioural model of the handshake timing and pixel value.
module tb_gaussian_conv_mac;

  localparam int MK = 31;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        kernel_size;
  logic [4:0]        norm_shift;
  logic              new_sample_ready;
  logic [MK*MK*8-1:0] working_memory;
  logic              end_pos;
  logic              new_trans, new_sample_req, update_pos, coeff_ren;
  logic [4:0]        coeff_x, coeff_y;
  logic [7:0]        coeff_rdata = '0;
  logic [7:0]        pix_out;
  logic              pix_valid;
  logic              pix_ready;
  logic              done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int win_a  [MK][MK];
  int coef_a [MK][MK];

  gaussian_conv_mac dut (
    .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size),
    .norm_shift(norm_shift), .new_sample_ready(new_sample_ready),
    .working_memory(working_memory), .end_pos(end_pos),
    .new_trans(new_trans), .new_sample_req(new_sample_req),
    .update_pos(update_pos), .coeff_x(coeff_x), .coeff_y(coeff_y),
    .coeff_ren(coeff_ren), .coeff_rdata(coeff_rdata), .pix_out(pix_out),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient table with one cycle of read latency.
  always @(posedge clk) if (coeff_ren) coeff_rdata <= 8'(coef_a[coeff_x][coeff_y]);

  // Window bus: pixel (x,y) at index x*MK + y.
  always_comb begin
    working_memory = '0;
    for (int x = 0; x < MK; x++)
      for (int y = 0; y < MK; y++)
        working_memory[(x*MK+y)*8 +: 8] = 8'(win_a[x][y]);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_pixel(input int k, input int s);
    longint sum = 0;
    for (int x = 0; x < k; x++)
      for (int y = 0; y < k; y++)
        sum += longint'(win_a[x][y]) * longint'(coef_a[x][y]);
    if (s > 0) sum += (longint'(1) << (s - 1));
    sum = sum >> s;
    return (sum > 255) ? 255 : int'(sum);
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  localparam int M_IDLE = 0, M_WAIT = 1, M_BUSY = 2;
  int m_state = M_IDLE;
  int m_k = 0, m_s = 0, m_req = 0, m_due = 0, m_pix = 0;
  bit m_done = 0;

  always @(negedge clk) begin
    bit exp_nt, exp_req, exp_valid, exp_acc, exp_ren;
    int idx;
    if (rst) begin
      chk("rst_pulses", {new_trans, new_sample_req, update_pos, coeff_ren, pix_valid, done}, 0);
      chk("rst_data", {pix_out, coeff_x, coeff_y}, 0);
      m_state = M_IDLE;
      m_done  = 0;
    end else begin
      exp_nt    = (m_state == M_IDLE) && start && (kernel_size != 0);
      exp_req   = (m_state == M_WAIT) && new_sample_ready;
      exp_valid = (m_state == M_BUSY) && (cyc >= m_due);
      exp_acc   = exp_valid && pix_ready;
      exp_ren   = (m_state == M_BUSY) && (cyc > m_req) && (cyc <= m_req + m_k * m_k);
      chk("m_new_trans", new_trans, exp_nt);
      chk("m_req", new_sample_req, exp_req);
      chk("m_valid", pix_valid, exp_valid);
      chk("m_update", update_pos, exp_acc && !end_pos);
      chk("m_done", done, m_done);
      chk("m_ren", coeff_ren, exp_ren);
      if (exp_valid) chk("m_pix", pix_out, m_pix);
      if (exp_ren) begin
        idx = cyc - m_req - 1;
        chk("m_cx", coeff_x, idx % m_k);
        chk("m_cy", coeff_y, idx / m_k);
      end
      if (exp_nt) begin
        m_k = kernel_size; m_s = norm_shift; m_done = 0; m_state = M_WAIT;
      end else if (exp_req) begin
        m_req = cyc; m_due = cyc + m_k * m_k + 3;
        m_pix = model_pixel(m_k, m_s); m_state = M_BUSY;
      end else if (exp_acc) begin
        if (end_pos) begin m_done = 1; m_state = M_IDLE; end
        else m_state = M_WAIT;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill_win(input int v);
    for (int x = 0; x < MK; x++) for (int y = 0; y < MK; y++) win_a[x][y] = v;
  endtask

  task automatic fill_coef(input int v);
    for (int x = 0; x < MK; x++) for (int y = 0; y < MK; y++) coef_a[x][y] = v;
  endtask

  task automatic start_frame(input int k, input int s);
    kernel_size = 5'(k); norm_shift = 5'(s); start = 1; #1;
    chk("lit_new_trans", new_trans, 1);
    tick();
    start = 0;
    chk("lit_done_clr", done, 0);
  endtask

  task automatic do_pixel(input int lit, input int exp_lat, input int hold,
                          input bit endp, input bit early);
    int n;
    new_sample_ready = 1; #1;
    n = 0;
    while (!new_sample_req && n < 50) begin tick(); n++; end
    chk("lit_req_seen", new_sample_req, 1);
    if (early) begin pix_ready = 1; end_pos = endp; end
    tick();
    n = 1;
    while (!pix_valid && n < 2000) begin tick(); n++; end
    chk("lit_latency", n, exp_lat);
    chk("lit_pix", pix_out, lit);
    repeat (hold) tick();
    if (hold > 0) chk("lit_pix_held", pix_out, lit);
    end_pos = endp; pix_ready = 1; #1;
    chk("lit_update", update_pos, !endp);
    tick();
    pix_ready = 0; end_pos = 0; new_sample_ready = 0; #1;
    chk("lit_valid_drop", pix_valid, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1; start = 0; kernel_size = 0; norm_shift = 0;
    new_sample_ready = 0; end_pos = 0; pix_ready = 0;
    fill_win(0); fill_coef(0);
    repeat (3) @(posedge clk);
    #1;
    chk("lit_reset_outs", {new_trans, new_sample_req, update_pos, coeff_ren, pix_valid, done}, 0);
    chk("lit_reset_pix", pix_out, 0);
    rst = 0;
    tick();

    // Frame 1: box filter, then saturation under backpressure, then frame end.
    fill_win(10); fill_coef(1);
    start_frame(3, 0);
    do_pixel(90, 12, 0, 0, 0);
    fill_win(255); fill_coef(255);
    do_pixel(255, 12, 20, 0, 0);
    fill_win(10); fill_coef(1);
    do_pixel(90, 12, 0, 1, 1);
    chk("lit_done_set", done, 1);

    // start with kernel_size 0 is ignored in DONE.
    kernel_size = 0; start = 1; #1;
    chk("lit_k0_trans", new_trans, 0);
    tick(); start = 0;
    chk("lit_k0_done", done, 1);

    // Frame 2: Gaussian 3x3, shift 4; mid-frame start ignored.
    fill_win(200); fill_coef(0);
    for (int x = 0; x < 3; x++)
      for (int y = 0; y < 3; y++)
        coef_a[x][y] = (x == 1 ? 2 : 1) * (y == 1 ? 2 : 1);
    start_frame(3, 4);
    do_pixel(200, 12, 0, 0, 1);
    kernel_size = 5; norm_shift = 0; start = 1; #1;
    chk("lit_mid_start", new_trans, 0);
    tick(); start = 0;
    fill_win(0); win_a[1][1] = 255;
    do_pixel(64, 12, 0, 1, 0);

    // Frames 3/4: rounding with k=1.
    fill_win(1); fill_coef(5);
    start_frame(1, 1);
    do_pixel(3, 4, 0, 1, 0);
    fill_coef(3);
    start_frame(1, 2);
    do_pixel(1, 4, 0, 1, 0);

    // Frame 5: largest window, full-scale data, no accumulator overflow.
    fill_win(255); fill_coef(255);
    start_frame(31, 18);
    do_pixel(238, 964, 0, 1, 0);

    // Frame 6: reset while in MAC.
    fill_win(10); fill_coef(1);
    start_frame(3, 0);
    new_sample_ready = 1; #1;
    n = 0;
    while (!new_sample_req && n < 50) begin tick(); n++; end
    chk("lit_req_seen6", new_sample_req, 1);
    repeat (3) tick();
    rst = 1; #1;
    chk("lit_rst_mid", {coeff_ren, pix_valid, done, new_sample_req, update_pos, new_trans}, 0);
    tick(); tick();
    rst = 0; new_sample_ready = 0;
    repeat (20) tick();
    chk("lit_rst_no_pix", pix_valid, 0);

    // Frame 7: asymmetric 2x2 pins the x/y orientation of both tables.
    fill_win(0); fill_coef(0);
    win_a[0][0] = 10; win_a[1][0] = 20; win_a[0][1] = 30; win_a[1][1] = 40;
    coef_a[0][0] = 1; coef_a[1][0] = 2; coef_a[0][1] = 3; coef_a[1][1] = 4;
    start_frame(2, 1);
    do_pixel(150, 7, 0, 1, 0);
    chk("lit_done_end", done, 1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
